pid_controller_mc: RTL and testbench
====================================

# pid_controller_mc

Multi-channel, time-multiplexed PID controller. It serves NUM_CH independent control loops through one shared multiplier. Each channel keeps its own gains, integrator and previous error, so the wall-follower can close several loops (e.g. heading, distance, per-wheel speed) with a single instance. Samples arrive over a valid/ready handshake tagged with a channel index, and results leave as a one-cycle pulse. The output saturates instead of wrapping.

## Interface
- PID_INT_WIDTH, 8, integer bits of unsigned gains
- PID_FRAC_WIDTH, 8, fractional bits of gains and of all internal terms
- PV_WIDTH, 9, unsigned setpoint/feedback width
- CONTROL_WIDTH, 16, signed output width
- NUM_CH, 4, channel count (≥1); CH_W = max(1, $clog2(NUM_CH))
- ACC_WIDTH, 32, signed integrator width (includes PID_FRAC_WIDTH fractional bits)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- k_p, k_i, k_d  in  NUM_CH×(PID_INT_WIDTH+PID_FRAC_WIDTH)  per-channel unsigned gains; sampled in the cycle they are used
- in_valid  in  1  sample offered
- in_ready  out  1  high in IDLE only
- in_ch  in  CH_W  channel index; values ≥ NUM_CH are accepted and produce no output and no state change
- in_clear  in  1  zero this channel's integrator and derivative history before computing
- setpoint, feedback  in  PV_WIDTH  unsigned
- out_valid  out  1  one-cycle result pulse; no backpressure
- out_ch  out  CH_W  channel of result
- error  out  PV_WIDTH+1  signed setpoint−feedback of result
- control_out  out  CONTROL_WIDTH  signed saturated output
- out_sat  out  1  control_out was clamped

## Operation
- FSM states and transitions: IDLE → ERR → MUL_P → MUL_I → MUL_D → SUM → OUT → IDLE. IDLE advances only on in_valid & in_ready.
- IDLE: in the accept cycle, latch in_ch, in_clear, setpoint and feedback.
- ERR: e = {0,sp} − {0,fb}, signed PV_WIDTH+1 bits. Read the channel state. If in_clear, use acc = 0, prev = 0 and primed = 0.
- MUL_P, MUL_I, MUL_D: compute one product per state through the shared signed multiplier. Operands are the gain zero-extended by 1 bit and the error in Q(PV_WIDTH+1).PID_FRAC_WIDTH.
  - u_p = k_p·e
  - u_i = sat_ACC(acc + k_i·e)
  - u_d = primed ? k_d·(e − prev) : 0
- SUM: s = u_p + u_i + u_d at full width (ACC_WIDTH+2).
  - control = floor(s / 2^PID_FRAC_WIDTH), using an arithmetic shift.
  - Clamp control to [−2^(CONTROL_WIDTH−1), 2^(CONTROL_WIDTH−1)−1] and set out_sat if clamped.
  - Write back acc (see Configuration), prev = e, primed = 1.
- OUT: out_valid = 1 for exactly one cycle. out_ch, error, control_out and out_sat are registered and hold until the next OUT.
- The integrator accumulates in the product format (Q.PID_FRAC_WIDTH). There is no division by sample time.
- Channels are fully independent. Interleaved samples never disturb other channels' state.

## Timing
- Reset values: state IDLE; out_valid 0; out_ch 0; error 0; control_out 0; out_sat 0; all acc, prev and primed cleared to 0. in_ready is 1 during and after reset.
- Latency: out_valid rises 6 cycles after the accept cycle.
- Throughput: one sample per 7 cycles. in_ready returns high in the cycle after OUT.
- Reset asserted mid-operation aborts the sample: no out_valid, and channel state is cleared.
- Gains may change between samples. Only the gain value present in the state that uses it matters.
- An invalid in_ch runs the FSM to IDLE with out_valid held 0.

## Configuration
- PID_ANTI_WINDUP_EN defined, conditional integration: if SUM saturates in the same direction as sign(e), acc keeps its previous value. Otherwise acc = u_i. The integrator itself saturates at the ACC_WIDTH limits.
- PID_ANTI_WINDUP_EN undefined: acc = acc + k_i·e, wrapping two's-complement at ACC_WIDTH. Output clamping is unchanged.

## Structure
- Package pid_pkg holds:
  - FSM state enum
  - gain typedef (unsigned PID_INT_WIDTH+PID_FRAC_WIDTH)
  - localparam width formulas (product, sum)
  - function sat_signed(value, width)
- Sub-module pid_saturate: combinational floor-shift plus clamp, producing control_out and out_sat. Also reused by the integrator clamp.
- Per-channel state lives in register arrays (NUM_CH is small). No RAM.

## Test plan
- P-only: ch0 k_p=0x0100, k_i=k_d=0, sp=300, fb=100 → error=200, control_out=200, out_ch=0, out_valid exactly 6 cycles after accept.
- Integral + isolation: ch1 k_i=0x0080, error 10 sent three times, interleaved with ch2 samples (error 0, all gains 0x0100) → ch1 outputs 5, 10, 15; ch2 outputs 0 every time.
- Derivative priming and clear: ch3 k_d=0x0200, error 5 → 0; then error 8 → 6; then in_clear with error 8 → 0.
- Saturation: k_p=0xFFFF, sp=511, fb=0 → control_out=32767, out_sat=1; sp=0, fb=511 → −32768, out_sat=1.
- Windup: k_i=0x0100, 70 samples of error 511, then error −511.
  - With PID_ANTI_WINDUP_EN: final output 32193, out_sat=0.
  - Without it: 32767, out_sat=1.
- Reset during MUL_I, then in_ch=5 with NUM_CH=4 → no out_valid for either; the next valid sample computes from cleared state.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types, width helpers and the signed clamp function for pid_controller_mc.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D,
    S_SUM,
    S_OUT
  } pid_state_t;

  localparam int PID_INT_WIDTH_DEF  = 8;
  localparam int PID_FRAC_WIDTH_DEF = 8;
  localparam int GAIN_WIDTH_DEF     = PID_INT_WIDTH_DEF + PID_FRAC_WIDTH_DEF;

  typedef logic [GAIN_WIDTH_DEF-1:0] gain_t;

  // Product of a zero-extended gain and an error difference (PV_WIDTH+2 bits).
  function automatic int prod_width(input int gain_w, input int pv_w);
    return (gain_w + 1) + (pv_w + 2);
  endfunction

  function automatic int sum_width(input int acc_w);
    return acc_w + 2;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pid_controller_mc_saturate.sv
// pid_saturate: arithmetic right shift (floor) followed by a signed clamp to OUT_W bits.
module pid_saturate
  import pid_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  logic signed [63:0] shifted;
  logic signed [63:0] clamped;

  always_comb begin
    shifted = 64'(din) >>> SHIFT;
    clamped = sat_signed(shifted, OUT_W);
    dout    = clamped[OUT_W-1:0];
    sat     = (clamped != shifted);
  end

endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID controller sharing one signed multiplier.
// Optional conditional-integration anti-windup is enabled by defining PID_ANTI_WINDUP_EN.
//
// state   | meaning
// IDLE    | in_ready high, wait for a sample
// ERR     | form error, fetch (or clear) channel state
// MUL_P   | proportional product
// MUL_I   | integral product, saturating accumulate
// MUL_D   | derivative product (zero until primed)
// SUM     | sum, shift, clamp, register outputs, write back channel state
// OUT     | one-cycle out_valid pulse
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int PID_INT_WIDTH  = 8,
  parameter int PID_FRAC_WIDTH = 8,
  parameter int PV_WIDTH       = 9,
  parameter int CONTROL_WIDTH  = 16,
  parameter int NUM_CH         = 4,
  parameter int ACC_WIDTH      = 32,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int GAIN_W        = PID_INT_WIDTH + PID_FRAC_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0][GAIN_W-1:0]     k_p,
  input  logic [NUM_CH-1:0][GAIN_W-1:0]     k_i,
  input  logic [NUM_CH-1:0][GAIN_W-1:0]     k_d,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CH_W-1:0]                   in_ch,
  input  logic                              in_clear,
  input  logic [PV_WIDTH-1:0]               setpoint,
  input  logic [PV_WIDTH-1:0]               feedback,
  output logic                              out_valid,
  output logic [CH_W-1:0]                   out_ch,
  output logic signed [PV_WIDTH:0]          error,
  output logic signed [CONTROL_WIDTH-1:0]   control_out,
  output logic                              out_sat
);

  localparam int E_W    = PV_WIDTH + 1;
  localparam int D_W    = PV_WIDTH + 2;
  localparam int MA_W   = GAIN_W + 1;
  localparam int PROD_W = prod_width(GAIN_W, PV_WIDTH);
  localparam int SUM_W  = sum_width(ACC_WIDTH);

  pid_state_t state, state_nxt;

  logic [CH_W-1:0]              ch_q;
  logic                         ch_ok_q;
  logic                         clr_q;
  logic [PV_WIDTH-1:0]          sp_q, fb_q;
  logic signed [E_W-1:0]        e_q, prev_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, ui_q, acc_upd_q;
  logic                         primed_q;
  logic signed [PROD_W-1:0]     up_q, ud_q;

  logic signed [ACC_WIDTH-1:0]  acc_mem [NUM_CH];
  logic signed [E_W-1:0]        prev_mem [NUM_CH];
  logic                         primed_mem [NUM_CH];

  logic [CH_W-1:0]              ch_idx;
  logic                         in_ch_ok;
  logic signed [MA_W-1:0]       mul_a;
  logic signed [D_W-1:0]        mul_b;
  logic signed [PROD_W-1:0]     mul_p;
  logic signed [ACC_WIDTH:0]    i_sum;
  logic signed [ACC_WIDTH-1:0]  ui_sat;
  logic                         ui_clamped;
  logic signed [SUM_W-1:0]      s_sum;
  logic signed [CONTROL_WIDTH-1:0] ctrl;
  logic                         ctrl_sat;
  logic signed [ACC_WIDTH-1:0]  acc_new;

  assign ch_idx   = ch_ok_q ? ch_q : '0;
  assign in_ch_ok = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ERR;
      end
      S_ERR:   state_nxt = S_MUL_P;
      S_MUL_P: state_nxt = S_MUL_I;
      S_MUL_I: state_nxt = S_MUL_D;
      S_MUL_D: state_nxt = S_SUM;
      S_SUM:   state_nxt = S_OUT;
      S_OUT: begin
        out_valid = ch_ok_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shared multiplier; operand selection follows the state.
  always_comb begin
    mul_a = '0;
    mul_b = D_W'(e_q);
    case (state)
      S_MUL_P: mul_a = {1'b0, k_p[ch_idx]};
      S_MUL_I: mul_a = {1'b0, k_i[ch_idx]};
      S_MUL_D: begin
        mul_a = {1'b0, k_d[ch_idx]};
        mul_b = D_W'(e_q) - D_W'(prev_q);
      end
      default: ;
    endcase
    mul_p = PROD_W'(mul_a) * PROD_W'(mul_b);
    i_sum = (ACC_WIDTH + 1)'(acc_q) + (ACC_WIDTH + 1)'(mul_p);
    s_sum = SUM_W'(up_q) + SUM_W'(ui_q) + SUM_W'(ud_q);
  end

  pid_saturate #(.IN_W(ACC_WIDTH + 1), .SHIFT(0), .OUT_W(ACC_WIDTH)) u_int_sat (
    .din  (i_sum),
    .dout (ui_sat),
    .sat  (ui_clamped)
  );

  pid_saturate #(.IN_W(SUM_W), .SHIFT(PID_FRAC_WIDTH), .OUT_W(CONTROL_WIDTH)) u_out_sat (
    .din  (s_sum),
    .dout (ctrl),
    .sat  (ctrl_sat)
  );

`ifdef PID_ANTI_WINDUP_EN
  logic e_pos, e_neg, hold;
  always_comb begin
    e_pos   = !e_q[E_W-1] && (e_q != '0);
    e_neg   = e_q[E_W-1];
    // Freeze the integrator while the output is pinned in the direction the error pushes.
    hold    = ctrl_sat && ((!s_sum[SUM_W-1] && e_pos) || (s_sum[SUM_W-1] && e_neg));
    acc_new = hold ? acc_q : acc_upd_q;
  end
`else
  assign acc_new = acc_upd_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      clr_q       <= 1'b0;
      sp_q        <= '0;
      fb_q        <= '0;
      e_q         <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      primed_q    <= 1'b0;
      up_q        <= '0;
      ui_q        <= '0;
      acc_upd_q   <= '0;
      ud_q        <= '0;
      out_ch      <= '0;
      error       <= '0;
      control_out <= '0;
      out_sat     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_mem[i]    <= '0;
        prev_mem[i]   <= '0;
        primed_mem[i] <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          ch_q    <= in_ch;
          ch_ok_q <= in_ch_ok;
          clr_q   <= in_clear;
          sp_q    <= setpoint;
          fb_q    <= feedback;
        end
        S_ERR: begin
          e_q      <= $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
          acc_q    <= clr_q ? '0 : acc_mem[ch_idx];
          prev_q   <= clr_q ? '0 : prev_mem[ch_idx];
          primed_q <= clr_q ? 1'b0 : primed_mem[ch_idx];
        end
        S_MUL_P: up_q <= mul_p;
        S_MUL_I: begin
          ui_q <= ui_sat;
`ifdef PID_ANTI_WINDUP_EN
          acc_upd_q <= ui_sat;
`else
          acc_upd_q <= i_sum[ACC_WIDTH-1:0];
`endif
        end
        S_MUL_D: ud_q <= primed_q ? mul_p : '0;
        S_SUM: if (ch_ok_q) begin
          out_ch              <= ch_q;
          error               <= e_q;
          control_out         <= ctrl;
          out_sat             <= ctrl_sat;
          acc_mem[ch_idx]     <= acc_new;
          prev_mem[ch_idx]    <= e_q;
          primed_mem[ch_idx]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller_mc.sv
// Scoreboard bench for pid_controller_mc: arithmetic reference model, random and directed samples.
module tb_pid_controller_mc;

  // Five channels on a 3-bit index leaves codes 5..7 as invalid channels.
  localparam int NUM_CH = 5;
  localparam int CH_W   = 3;
  localparam int GW     = 16;
  localparam int PV     = 9;
  localparam int CW     = 16;
  localparam int T      = 10;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0][GW-1:0] k_p, k_i, k_d;
  logic in_valid, in_ready, in_clear;
  logic [CH_W-1:0] in_ch;
  logic [PV-1:0] setpoint, feedback;
  logic out_valid, out_sat;
  logic [CH_W-1:0] out_ch;
  logic signed [PV:0] error;
  logic signed [CW-1:0] control_out;

  pid_controller_mc #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_clear(in_clear),
    .setpoint(setpoint), .feedback(feedback), .out_valid(out_valid), .out_ch(out_ch),
    .error(error), .control_out(control_out), .out_sat(out_sat)
  );

  always #(T/2) clk = ~clk;

  typedef struct {
    longint ch;
    longint err;
    longint ctrl;
    longint sat;
    time    t_acc;
  } exp_t;

  exp_t   sb[$];
  int     n_chk = 0;
  int     n_bad = 0;
  longint m_acc[NUM_CH];
  longint m_prev[NUM_CH];
  bit     m_primed[NUM_CH];
  longint last_ctrl = 0;
  longint last_sat = 0;

  task automatic check(input string name, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0; m_prev[i] = 0; m_primed[i] = 0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!reset && out_valid) begin
      if (sb.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        x = sb.pop_front();
        check("out_ch", longint'(out_ch), x.ch);
        check("error", longint'(error), x.err);
        check("control_out", longint'(control_out), x.ctrl);
        check("out_sat", longint'(out_sat), x.sat);
        check("latency", longint'($time - x.t_acc), 55);
        last_ctrl = longint'(control_out);
        last_sat  = longint'(out_sat);
      end
    end
  end

  task automatic send(input int ch, input bit clr, input int sp, input int fb);
    int g;
    time tacc;
    longint e, kp, ki, kd, prod_i, up, ui, ud, s, c, cc, wsat;
    bit hold;
    exp_t x;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 40) begin @(negedge clk); g++; end
    if (!in_ready) begin check("in_ready_timeout", 0, 1); return; end
    in_valid = 1'b1; in_ch = CH_W'(ch); in_clear = clr;
    setpoint = PV'(sp); feedback = PV'(fb);
    @(posedge clk);
    tacc = $time;
    #1 in_valid = 1'b0; in_clear = 1'b0;
    if (ch < NUM_CH) begin
      kp = longint'(k_p[ch]); ki = longint'(k_i[ch]); kd = longint'(k_d[ch]);
      e = longint'(sp) - longint'(fb);
      if (clr) begin m_acc[ch] = 0; m_prev[ch] = 0; m_primed[ch] = 0; end
      prod_i = ki * e;
      up = kp * e;
      ui = clamp(m_acc[ch] + prod_i, 32);
      ud = m_primed[ch] ? kd * (e - m_prev[ch]) : 0;
      s  = up + ui + ud;
      c  = s >>> 8;
      cc = clamp(c, CW);
      wsat = (cc != c) ? 1 : 0;
`ifdef PID_ANTI_WINDUP_EN
      hold = (wsat == 1) && ((s > 0 && e > 0) || (s < 0 && e < 0));
      if (!hold) m_acc[ch] = ui;
`else
      hold = 1'b0;
      m_acc[ch] = longint'(int'(m_acc[ch] + prod_i));
`endif
      m_prev[ch] = e;
      m_primed[ch] = 1'b1;
      x.ch = ch; x.err = e; x.ctrl = cc; x.sat = wsat; x.t_acc = tacc;
      sb.push_back(x);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end
    while (!(in_ready && sb.size() == 0) && g < 100);
    if (g >= 100) check("idle_timeout", 0, 1);
  endtask

  task automatic set_gains(input int ch, input int kp, input int ki, input int kd);
    k_p[ch] = GW'(kp); k_i[ch] = GW'(ki); k_d[ch] = GW'(kd);
  endtask

  initial begin
    #(T * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_clear = 1'b0; in_ch = '0;
    setpoint = '0; feedback = '0; k_p = '0; k_i = '0; k_d = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    check("rst_error", longint'(error), 0);
    check("rst_control", longint'(control_out), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    reset = 1'b0;

    set_gains(0, 16'h0100, 0, 0);
    send(0, 0, 300, 100);
    wait_idle();
    check("p_only", last_ctrl, 200);

    set_gains(1, 0, 16'h0080, 0);
    set_gains(2, 16'h0100, 16'h0100, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 110, 100);
      send(2, 0, 50, 50);
    end
    wait_idle();

    set_gains(3, 0, 0, 16'h0200);
    send(3, 0, 5, 0);
    send(3, 0, 8, 0);
    wait_idle();
    check("d_primed", last_ctrl, 6);
    send(3, 1, 8, 0);
    wait_idle();
    check("d_clear", last_ctrl, 0);

    set_gains(0, 16'hFFFF, 0, 0);
    send(0, 1, 511, 0);
    wait_idle();
    check("sat_pos", last_ctrl, 32767);
    check("sat_pos_flag", last_sat, 1);
    send(0, 1, 0, 511);
    wait_idle();
    check("sat_neg", last_ctrl, -32768);
    check("sat_neg_flag", last_sat, 1);

    set_gains(4, 0, 16'h0100, 0);
    send(4, 1, 511, 0);
    for (int i = 1; i < 70; i++) send(4, 0, 511, 0);
    send(4, 0, 0, 511);
    wait_idle();
`ifdef PID_ANTI_WINDUP_EN
    check("windup_final", last_ctrl, 32193);
    check("windup_sat", last_sat, 0);
`else
    check("windup_final", last_ctrl, 32767);
    check("windup_sat", last_sat, 1);
`endif

    for (int n = 0; n < 80; n++) begin
      int ch;
      wait_idle();
      ch = int'($urandom_range(0, 7));
      if (ch < NUM_CH)
        set_gains(ch,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16'hFFFF)) : int'($urandom_range(0, 16'h03FF)),
                  int'($urandom_range(0, 16'h01FF)),
                  int'($urandom_range(0, 16'h07FF)));
      send(ch, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    end
    wait_idle();

    // Abort a sample in MUL_I with reset, then push an invalid channel.
    set_gains(1, 0, 16'h0080, 0);
    send(1, 0, 300, 0);
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; in_ch = 3'd1; setpoint = 9'd200; feedback = 9'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_control", longint'(control_out), 0);
    @(negedge clk);
    reset = 1'b0;
    send(5, 0, 400, 0);
    repeat (12) @(negedge clk);
    send(1, 0, 110, 100);
    wait_idle();
    check("after_reset", last_ctrl, 5);

    wait_idle();
    check("scoreboard_drain", longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
